uart_rx_fifo: RTL and testbench

Receive FIFO for the 16550-compatible UART, sitting directly downstream of the receiver. It captures each completed character together with its parity and framing error flags on the receiver's one-cycle ready pulse, and presents the oldest entry to the register interface (RBR read). It also generates the line-status flags (data ready, overrun, error-in-FIFO) and the receive-trigger and character-timeout interrupt conditions.

---
 rtl/uart_rx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the 16550 UART: stores {fe, pe, data}, derives LSR flags, trigger and timeout; RX_FIFO_TIMEOUT_EN enables the character timeout.
// Latency: head entry is combinational from storage, visible the cycle after the write edge; flags update on the strobe edge.
// Backpressure: none toward the receiver; a write into a full FIFO is dropped and sets the sticky overrun flag.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       baud_tick,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_pe,
    input  logic                       wr_fe,
    input  logic                       rd_en,
    input  logic                       lsr_rd,
    input  logic                       fifo_en,
    input  logic                       fifo_clr,
    input  logic [1:0]                 trig_sel,
    output logic [7:0]                 rd_data,
    output logic                       rd_pe,
    output logic                       rd_fe,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       data_ready,
    output logic                       overrun,
    output logic                       err_in_fifo,
    output logic                       trig_hit,
    output logic                       timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          fifo_en_q;
    logic [CW-1:0] cap;
    logic          full;
    logic          flush;
    logic          do_rd;
    logic          do_wr;
    logic          ovr_evt;
    int            trig_lvl;

    assign cap     = fifo_en ? CW'(DEPTH) : CW'(1);
    assign full    = (count == cap);
    // A mode change empties the FIFO exactly like an FCR flush.
    assign flush   = fifo_clr || (fifo_en != fifo_en_q);
    assign do_rd   = rd_en && (count != '0) && !flush;
    assign do_wr   = wr_en && (!full || do_rd) && !flush;
    assign ovr_evt = wr_en && full && !rd_en && !flush;

    assign {rd_fe, rd_pe, rd_data} = mem[rd_ptr];
    assign data_ready = (count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= {wr_fe, wr_pe, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            fifo_en_q <= 1'b0;
        end else begin
            fifo_en_q <= fifo_en;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
                if (do_wr && !do_rd)      count <= count + 1'b1;
                else if (!do_wr && do_rd) count <= count - 1'b1;
            end
            if (ovr_evt)     overrun <= 1'b1;
            else if (lsr_rd) overrun <= 1'b0;
        end
    end

    // Only slots between head and head+count hold live entries.
    always_comb begin
        logic [PW-1:0] off;
        off         = '0;
        err_in_fifo = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < count) && (mem[i][9:8] != 2'b00)) begin
                err_in_fifo = 1'b1;
            end
        end
    end

    always_comb begin
        case (trig_sel)
            2'b00:   trig_lvl = 1;
            2'b01:   trig_lvl = 4;
            2'b10:   trig_lvl = 8;
            default: trig_lvl = 14;
        endcase
        trig_hit = fifo_en ? (int'(count) >= trig_lvl) : data_ready;
    end

`ifdef RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (flush || wr_en || rd_en || (count == '0)) begin
            tmo_cnt <= '0;
            if (flush || wr_en || rd_en) timeout <= 1'b0;
        end else if (baud_tick && !timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TW'(TIMEOUT_BITS - 1)) timeout <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_bits = TIMEOUT_BITS;
    logic unused_baud_tick;
    assign unused_baud_tick = baud_tick;
    assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random strobes against a queue-based model; honours RX_FIFO_TIMEOUT_EN.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TBITS = 40;
`ifdef RX_FIFO_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick, wr_en, wr_pe, wr_fe, rd_en, lsr_rd, fifo_en, fifo_clr;
    logic [7:0] wr_data;
    logic [1:0] trig_sel;
    logic [7:0] rd_data;
    logic       rd_pe, rd_fe, data_ready, overrun, err_in_fifo, trig_hit, timeout;
    logic [4:0] count;

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_BITS(TBITS)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en), .wr_data(wr_data),
        .wr_pe(wr_pe), .wr_fe(wr_fe), .rd_en(rd_en), .lsr_rd(lsr_rd), .fifo_en(fifo_en),
        .fifo_clr(fifo_clr), .trig_sel(trig_sel), .rd_data(rd_data), .rd_pe(rd_pe),
        .rd_fe(rd_fe), .count(count), .data_ready(data_ready), .overrun(overrun),
        .err_in_fifo(err_in_fifo), .trig_hit(trig_hit), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: queue of {fe, pe, data}, sticky overrun, previous mode, idle bit counter.
    logic [9:0] mq [$];
    bit         m_ovr;
    bit         m_en_prev;
    int         m_idle;
    bit         m_tmo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int level(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 14;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovr     = 0;
        m_en_prev = 0;
        m_idle    = 0;
        m_tmo     = 0;
    endtask

    task automatic model_step();
        int  n    = mq.size();
        int  cap  = fifo_en ? DEPTH : 1;
        bit  fl   = fifo_clr || (fifo_en != m_en_prev);
        bit  r_ok = rd_en && n > 0;
        m_en_prev = fifo_en;
        if (fl) begin
            mq.delete();
        end else begin
            if (wr_en && n == cap && !rd_en) m_ovr = 1;
            else if (lsr_rd)                 m_ovr = 0;
            if (r_ok) void'(mq.pop_front());
            if (wr_en && (n < cap || r_ok)) mq.push_back({wr_fe, wr_pe, wr_data});
        end
        if (fl && lsr_rd) m_ovr = 0;
        if (TMO_EN) begin
            if (fl || wr_en || rd_en) begin
                m_idle = 0;
                m_tmo  = 0;
            end else if (n == 0) begin
                m_idle = 0;
            end else if (baud_tick && !m_tmo) begin
                m_idle++;
                if (m_idle == TBITS) m_tmo = 1;
            end
        end
    endtask

    task automatic compare();
        bit e = 0;
        foreach (mq[i]) if (mq[i][9:8] != 2'b00) e = 1;
        check("count", 32'(count), mq.size());
        check("data_ready", 32'(data_ready), 32'(mq.size() != 0));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("err_in_fifo", 32'(err_in_fifo), 32'(e));
        check("trig_hit", 32'(trig_hit),
              32'(fifo_en ? (mq.size() >= level(trig_sel)) : (mq.size() != 0)));
        check("timeout", 32'(timeout), 32'(m_tmo));
        if (mq.size() != 0) check("head", 32'({rd_fe, rd_pe, rd_data}), 32'(mq[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        wr_en = 0; rd_en = 0; lsr_rd = 0; fifo_clr = 0; baud_tick = 0;
        wr_pe = 0; wr_fe = 0;
    endtask

    task automatic wr(input logic [7:0] d, input logic pe, input logic fe);
        wr_en = 1; wr_data = d; wr_pe = pe; wr_fe = fe;
        tick();
    endtask

    task automatic rd();
        rd_en = 1;
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2 && mq.size() != 0; k++) rd();
        lsr_rd = 1;
        tick();
    endtask

    initial begin
        int wp, rp;
        rst = 0; baud_tick = 0; wr_en = 0; wr_data = 0; wr_pe = 0; wr_fe = 0;
        rd_en = 0; lsr_rd = 0; fifo_en = 1; fifo_clr = 0; trig_sel = 0;
        model_reset();
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_dready", 32'(data_ready), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_rdata", 32'({rd_fe, rd_pe, rd_data}), 0);
        check("rst_err", 32'(err_in_fifo), 0);
        check("rst_trig", 32'(trig_hit), 0);
        check("rst_tmo", 32'(timeout), 0);
        @(negedge clk);
        rst = 1;
        tick();

        // Reset mid-stream, asserted between edges.
        wr(8'h01, 0, 0); wr(8'h02, 0, 0); wr(8'h03, 1, 0);
        check("pre_rst_count", 32'(count), 3);
        #2 rst = 0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_dready", 32'(data_ready), 0);
        check("arst_ovr", 32'(overrun), 0);
        check("arst_rdata", 32'(rd_data), 0);
        model_reset();
        @(negedge clk);
        rst = 1;
        tick();

        // Fill, overrun, in-order readout, overrun clear.
        for (int i = 0; i < 16; i++) wr(8'(i), 0, 0);
        wr(8'hAA, 0, 0);
        check("fill_count", 32'(count), 16);
        check("fill_ovr", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            check("fill_order", 32'(rd_data), i);
            rd();
        end
        check("fill_empty", 32'(count), 0);
        lsr_rd = 1;
        tick();
        check("ovr_clear", 32'(overrun), 0);

        // Simultaneous write and read while full.
        for (int i = 0; i < 16; i++) wr(8'(8'h60 + i), 0, 0);
        wr_en = 1; wr_data = 8'h55; rd_en = 1;
        tick();
        check("full_rw_count", 32'(count), 16);
        check("full_rw_ovr", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("full_rw_last", 32'(rd_data), 8'h55);
            rd();
        end

        // Error flags and trigger level 4.
        trig_sel = 2'b01;
        wr(8'h41, 1, 0); wr(8'h42, 0, 0); wr(8'h43, 0, 0);
        check("trig4_lo", 32'(trig_hit), 0);
        check("err_set", 32'(err_in_fifo), 1);
        wr(8'h44, 0, 0);
        check("trig4_hi", 32'(trig_hit), 1);
        check("err_head_pe", 32'({rd_pe, rd_data}), 9'h141);
        rd();
        check("err_clear", 32'(err_in_fifo), 0);
        drain();

        // 16450 single-entry mode.
        fifo_en = 0;
        tick();
        wr(8'h11, 0, 0); wr(8'h22, 0, 0);
        check("m450_count", 32'(count), 1);
        check("m450_ovr", 32'(overrun), 1);
        check("m450_data", 32'(rd_data), 8'h11);
        check("m450_trig", 32'(trig_hit), 1);
        fifo_en = 1;
        tick();
        check("mode_flush", 32'(count), 0);
        lsr_rd = 1;
        tick();

        // Character timeout.
        wr(8'h33, 0, 0);
        for (int k = 1; k <= TBITS; k++) begin
            baud_tick = 1;
            tick();
            if (k == TBITS - 1) check("tmo_early", 32'(timeout), 0);
            if (k == TBITS)     check("tmo_set", 32'(timeout), 32'(TMO_EN));
        end
        rd();
        check("tmo_clr", 32'(timeout), 0);
        check("tmo_count", 32'(count), 0);

        // Random traffic in phases of differing write/read pressure.
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin wp = 60; rp = 20; end
                1: begin wp = 20; rp = 60; end
                2: begin wp = 2;  rp = 1;  end
                3: begin wp = 50; rp = 50; end
                4: begin wp = 90; rp = 5;  end
                default: begin wp = 1; rp = 1; end
            endcase
            for (int c = 0; c < 500; c++) begin
                wr_en     = $urandom_range(0, 99) < wp;
                rd_en     = $urandom_range(0, 99) < rp;
                wr_data   = 8'($urandom);
                wr_pe     = $urandom_range(0, 7) == 0;
                wr_fe     = $urandom_range(0, 7) == 0;
                lsr_rd    = $urandom_range(0, 9) == 0;
                fifo_clr  = $urandom_range(0, 199) == 0;
                baud_tick = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 299) == 0) fifo_en = ~fifo_en;
                if ($urandom_range(0, 49) == 0)  trig_sel = 2'($urandom);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
